// File: rtl/eth_tx_pkg.sv
// Shared encodings and field sizes for the RMII transmit frame controller.
package eth_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PREAMBLE  = 4'd1,
    ST_SFD       = 4'd2,
    ST_DEST_ADDR = 4'd3,
    ST_SRC_ADDR  = 4'd4,
    ST_LEN_TYPE  = 4'd5,
    ST_DATA      = 4'd6,
    ST_PAD       = 4'd7,
    ST_FCS       = 4'd8,
    ST_IFG       = 4'd9
  } tx_state_e;

  localparam int SFD_BYTES      = 1;
  localparam int MAC_BYTES      = 6;
  localparam int LEN_TYPE_BYTES = 2;
  localparam int FCS_BYTES      = 4;

  localparam int DEF_CYC_PER_BYTE   = 4;
  localparam int DEF_PREAMBLE_BYTES = 7;
  localparam int DEF_IFG_BYTES      = 12;
  localparam int DEF_MIN_PAYLOAD    = 46;
  localparam int DEF_MAX_PAYLOAD    = 1500;
  localparam int DEF_LEN_W          = 11;

  function automatic logic on_wire(input tx_state_e s);
    return (s != ST_IDLE) && (s != ST_IFG);
  endfunction

endpackage

// File: rtl/eth_tx_byte_pacer.sv
// Dibit phase counter within a wire byte; flags the last phase as the byte boundary.
module eth_tx_byte_pacer #(
  parameter int pCyc_Per_Byte = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       i_clr,
  input  logic       i_hold,
  output logic [2:0] o_phase,
  output logic       o_boundary
);

  localparam logic [2:0] LP_LAST = 3'(pCyc_Per_Byte - 1);

  logic [2:0] r_phase;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_phase <= '0;
    end else if (i_clr || i_hold || (r_phase == LP_LAST)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 3'd1;
    end
  end

  assign o_phase    = r_phase;
  assign o_boundary = !i_hold && (r_phase == LP_LAST);

endmodule

// File: rtl/eth_tx_frame_ctrl.sv
// RMII transmit frame sequencer: preamble, header, FIFO payload, pad, FCS and IFG,
// each field timed by a down-counter of remaining bytes that reloads on state change.
module eth_tx_frame_ctrl
  import eth_tx_pkg::*;
#(
  parameter int pCyc_Per_Byte   = DEF_CYC_PER_BYTE,
  parameter int pPreamble_Bytes = DEF_PREAMBLE_BYTES,
  parameter int pMin_Payload    = DEF_MIN_PAYLOAD,
  parameter int pMax_Payload    = DEF_MAX_PAYLOAD,
  parameter int pIfg_Bytes      = DEF_IFG_BYTES,
  parameter int pLen_W          = DEF_LEN_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Eth_En,
  input  logic              Tx_Abort,
  input  logic              Fifo_Empty,
  output logic [3:0]        Tx_Ctrl_FSM_State,
  output logic              Tx_En,
  output logic              Fifo_Rd,
  output logic              Crc_Init,
  output logic              Crc_En,
  output logic [2:0]        Byte_Phase,
  output logic [2:0]        Byte_Idx,
  output logic              Pad_Sel,
  output logic              Fcs_Sel,
  output logic [pLen_W-1:0] Payload_Len,
  output logic              Frame_Done,
  output logic              Frame_Abort,
  output logic              Len_Err
);

  localparam logic [pLen_W-1:0] LP_ONE = pLen_W'(1);
  localparam logic [pLen_W-1:0] LP_MIN = pLen_W'(pMin_Payload);
  localparam logic [pLen_W-1:0] LP_MAX = pLen_W'(pMax_Payload);

  tx_state_e         r_state;
  tx_state_e         w_next;
  logic [pLen_W-1:0] r_left;
  logic [pLen_W-1:0] w_load;
  logic [pLen_W-1:0] r_len;
  logic [pLen_W-1:0] w_len_inc;
  logic [2:0]        r_idx;
  logic [2:0]        w_phase;
  logic              w_bnd;
  logic              w_abort;
  logic              w_field_end;
  logic              w_data_exit;
  logic              r_crc_init;
  logic              r_abort_pulse;

  eth_tx_byte_pacer #(
    .pCyc_Per_Byte(pCyc_Per_Byte)
  ) u_pacer (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .i_clr     (w_abort),
    .i_hold    (r_state == ST_IDLE),
    .o_phase   (w_phase),
    .o_boundary(w_bnd)
  );

  assign w_abort     = Tx_Abort && on_wire(r_state);
  assign w_field_end = w_bnd && (r_left == '0);
  assign w_len_inc   = r_len + LP_ONE;
  assign w_data_exit = w_bnd && (Fifo_Empty || (w_len_inc == LP_MAX));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (Eth_En)      w_next = ST_PREAMBLE;
      ST_PREAMBLE:  if (w_field_end) w_next = ST_SFD;
      ST_SFD:       if (w_field_end) w_next = ST_DEST_ADDR;
      ST_DEST_ADDR: if (w_field_end) w_next = ST_SRC_ADDR;
      ST_SRC_ADDR:  if (w_field_end) w_next = ST_LEN_TYPE;
      ST_LEN_TYPE:  if (w_field_end) w_next = Fifo_Empty ? ST_PAD : ST_DATA;
      ST_DATA:      if (w_data_exit) w_next = (w_len_inc < LP_MIN) ? ST_PAD : ST_FCS;
      ST_PAD:       if (w_field_end) w_next = ST_FCS;
      ST_FCS:       if (w_field_end) w_next = ST_IFG;
      ST_IFG:       if (w_field_end) w_next = ST_IDLE;
      default:                       w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IFG;
  end

  // Byte count (minus one) of the field being entered; pad only tops up the payload.
  always_comb begin
    w_load = '0;
    case (w_next)
      ST_PREAMBLE:              w_load = pLen_W'(pPreamble_Bytes - 1);
      ST_SFD:                   w_load = pLen_W'(SFD_BYTES - 1);
      ST_DEST_ADDR,
      ST_SRC_ADDR:              w_load = pLen_W'(MAC_BYTES - 1);
      ST_LEN_TYPE:              w_load = pLen_W'(LEN_TYPE_BYTES - 1);
      ST_PAD:                   w_load = (r_state == ST_DATA) ? (LP_MIN - w_len_inc - LP_ONE)
                                                              : (LP_MIN - LP_ONE);
      ST_FCS:                   w_load = pLen_W'(FCS_BYTES - 1);
      ST_IFG:                   w_load = pLen_W'(pIfg_Bytes - 1);
      default:                  w_load = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_left        <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_crc_init    <= 1'b0;
      r_abort_pulse <= 1'b0;
    end else begin
      r_crc_init    <= (r_state == ST_IDLE) && Eth_En;
      r_abort_pulse <= w_abort;
      if (w_next != r_state) begin
        r_left <= w_load;
        r_idx  <= '0;
      end else if (w_bnd) begin
        r_idx <= r_idx + 3'd1;
        if (r_left != '0) r_left <= r_left - LP_ONE;
      end
      if ((r_state == ST_IDLE) && Eth_En) begin
        r_len <= '0;
      end else if ((r_state == ST_DATA) && w_bnd && !w_abort) begin
        r_len <= w_len_inc;
      end
    end
  end

  always_comb begin
    Tx_En      = on_wire(r_state);
    Crc_En     = (r_state >= ST_DEST_ADDR) && (r_state <= ST_PAD);
    Fifo_Rd    = (r_state == ST_DATA) && (w_phase == 3'd0);
    Pad_Sel    = (r_state == ST_PAD);
    Fcs_Sel    = (r_state == ST_FCS);
    Frame_Done = (r_state == ST_FCS) && w_field_end && !w_abort;
    Len_Err    = (r_state == ST_DATA) && w_data_exit && !Fifo_Empty && !w_abort;
  end

  assign Tx_Ctrl_FSM_State = r_state;
  assign Byte_Phase        = w_phase;
  assign Byte_Idx          = r_idx;
  assign Payload_Len       = r_len;
  assign Crc_Init          = r_crc_init;
  assign Frame_Abort       = r_abort_pulse;

endmodule

// File: tb/tb_eth_tx_frame_ctrl.sv
// Frame-level scoreboard bench: expected frame records queued at launch, observed
// records built by a monitor at each IFG exit, compared in order.
module tb_eth_tx_frame_ctrl;

  typedef struct {
    int dut, tx, rd, pad, crc, fcs, err, done, abort, ifg, plen, done_at, idx_done, start, exit_c;
  } rec_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic        en[2], ab[2], fe[2];
  logic        tx[2], rd[2], ci[2], ce[2], pad[2], fcs[2], done[2], abrt[2], lerr[2];
  logic [3:0]  st[2];
  logic [2:0]  ph[2], idx[2];
  logic [10:0] plen[2];
  int          pushed[2], popped[2];
  int          cyc;
  int          total = 0;
  int          bad = 0;
  rec_t        exp_q[$];
  rec_t        obs_q[$];
  rec_t        cur[2];
  logic [3:0]  prev[2];

  assign fe[0] = (pushed[0] == popped[0]);
  assign fe[1] = (pushed[1] == popped[1]);

  eth_tx_frame_ctrl dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Eth_En(en[0]), .Tx_Abort(ab[0]), .Fifo_Empty(fe[0]),
    .Tx_Ctrl_FSM_State(st[0]), .Tx_En(tx[0]), .Fifo_Rd(rd[0]), .Crc_Init(ci[0]),
    .Crc_En(ce[0]), .Byte_Phase(ph[0]), .Byte_Idx(idx[0]), .Pad_Sel(pad[0]),
    .Fcs_Sel(fcs[0]), .Payload_Len(plen[0]), .Frame_Done(done[0]),
    .Frame_Abort(abrt[0]), .Len_Err(lerr[0])
  );

  eth_tx_frame_ctrl #(.pMax_Payload(60)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Eth_En(en[1]), .Tx_Abort(ab[1]), .Fifo_Empty(fe[1]),
    .Tx_Ctrl_FSM_State(st[1]), .Tx_En(tx[1]), .Fifo_Rd(rd[1]), .Crc_Init(ci[1]),
    .Crc_En(ce[1]), .Byte_Phase(ph[1]), .Byte_Idx(idx[1]), .Pad_Sel(pad[1]),
    .Fcs_Sel(fcs[1]), .Payload_Len(plen[1]), .Frame_Done(done[1]),
    .Frame_Abort(abrt[1]), .Len_Err(lerr[1])
  );

  // Monitor: FIFO read consumption plus per-frame activity, sampled on the falling edge.
  initial begin
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      popped[k] = 0;
      prev[k]   = 4'd0;
      cur[k]    = '{default: 0};
    end
    forever begin
      @(negedge Clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!Rst_n) begin
          prev[k] = 4'd0;
          continue;
        end
        if (rd[k]) popped[k]++;
        if (ci[k]) begin
          cur[k]       = '{default: 0};
          cur[k].dut   = k;
          cur[k].start = cyc;
        end
        cur[k].tx    += int'(tx[k]);
        cur[k].rd    += int'(rd[k]);
        cur[k].pad   += int'(pad[k]);
        cur[k].crc   += int'(ce[k]);
        cur[k].fcs   += int'(fcs[k]);
        cur[k].err   += int'(lerr[k]);
        cur[k].abort += int'(abrt[k]);
        if (done[k]) begin
          cur[k].done++;
          cur[k].done_at  = cur[k].tx;
          cur[k].idx_done = int'(idx[k]);
        end
        if (st[k] == 4'd9) cur[k].ifg++;
        if (prev[k] == 4'd9 && st[k] != 4'd9) begin
          cur[k].exit_c = cyc;
          cur[k].plen   = int'(plen[k]);
          obs_q.push_back(cur[k]);
        end
        prev[k] = st[k];
      end
    end
  end

  task automatic cmp(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic rec_t exp_frame(input int k, input int n, input int pmax);
    rec_t r;
    int take, pd;
    r = '{default: 0};
    take = (n < pmax) ? n : pmax;
    pd = (take < 46) ? 46 - take : 0;
    r.dut = k;
    r.tx = (7 + 1 + 6 + 6 + 2 + take + pd + 4) * 4;
    r.rd = take;
    r.pad = pd * 4;
    r.crc = (6 + 6 + 2 + take + pd) * 4;
    r.fcs = 16;
    r.err = (n > pmax) ? 1 : 0;
    r.done = 1;
    r.ifg = 48;
    r.plen = take;
    r.done_at = r.tx;
    r.idx_done = 3;
    return r;
  endfunction

  task automatic wait_obs(input int n, input int budget);
    int w = 0;
    while (obs_q.size() < n && w < budget) begin
      @(negedge Clk);
      w++;
    end
    if (obs_q.size() < n) cmp("frame_timeout", obs_q.size(), n);
  endtask

  task automatic wait_state(input int k, input int s, input int budget);
    int w = 0;
    while (int'(st[k]) != s && w < budget) begin
      @(negedge Clk);
      w++;
    end
    if (int'(st[k]) != s) cmp("state_timeout", int'(st[k]), s);
  endtask

  task automatic pulse(input int k);
    @(negedge Clk);
    en[k] = 1'b1;
    @(negedge Clk);
    en[k] = 1'b0;
  endtask

  task automatic compare_next(output rec_t o);
    rec_t e;
    o = '{default: 0};
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      cmp("frame_missing", obs_q.size(), exp_q.size() + 1);
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      cmp("dut_id", o.dut, e.dut);
      cmp("tx_en_cycles", o.tx, e.tx);
      cmp("fifo_rd_pulses", o.rd, e.rd);
      cmp("pad_cycles", o.pad, e.pad);
      cmp("crc_en_cycles", o.crc, e.crc);
      cmp("fcs_cycles", o.fcs, e.fcs);
      cmp("len_err_pulses", o.err, e.err);
      cmp("frame_done_pulses", o.done, e.done);
      cmp("frame_abort_pulses", o.abort, e.abort);
      cmp("ifg_cycles", o.ifg, e.ifg);
      cmp("payload_len", o.plen, e.plen);
      cmp("done_cycle", o.done_at, e.done_at);
      cmp("done_byte_idx", o.idx_done, e.idx_done);
    end
  endtask

  initial begin
    rec_t o1, o2, ea;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0;
      ab[k] = 1'b0;
      pushed[k] = 0;
    end

    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    cmp("rst_state", int'(st[0]), 0);
    cmp("rst_tx_en", int'(tx[0]), 0);
    cmp("rst_others", int'({rd[0], ci[0], ce[0], ph[0], idx[0], pad[0], fcs[0],
                            plen[0], done[0], abrt[0], lerr[0]}), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 10-byte payload, padded
    pushed[0] += 10;
    exp_q.push_back(exp_frame(0, 10, 1500));
    pulse(0);
    wait_obs(1, 1500);
    compare_next(o1);

    // 100-byte payload, no pad
    pushed[0] += 100;
    exp_q.push_back(exp_frame(0, 100, 1500));
    pulse(0);
    wait_obs(1, 1500);
    compare_next(o1);

    // empty FIFO at LEN_TYPE exit
    exp_q.push_back(exp_frame(0, 0, 1500));
    pulse(0);
    wait_obs(1, 1500);
    compare_next(o1);

    // truncation at 60, remainder carried into the next frame
    pushed[1] += 80;
    exp_q.push_back(exp_frame(1, 80, 60));
    pulse(1);
    wait_obs(1, 1500);
    compare_next(o1);
    exp_q.push_back(exp_frame(1, 20, 60));
    pulse(1);
    wait_obs(1, 1500);
    compare_next(o1);
    cmp("fifo_remaining", pushed[1] - popped[1], 0);

    // abort in SRC_ADDR with Eth_En held; restart one clock after IFG
    ea = '{default: 0};
    ea.tx = 62;
    ea.crc = 30;
    ea.abort = 1;
    ea.ifg = 48;
    exp_q.push_back(ea);
    exp_q.push_back(exp_frame(0, 0, 1500));
    @(negedge Clk);
    en[0] = 1'b1;
    wait_state(0, 4, 300);
    repeat (5) @(negedge Clk);
    ab[0] = 1'b1;
    @(negedge Clk);
    ab[0] = 1'b0;
    wait_obs(1, 500);
    wait_state(0, 1, 100);
    en[0] = 1'b0;
    wait_obs(2, 1500);
    compare_next(o1);
    compare_next(o2);
    cmp("restart_gap", o2.start - o1.exit_c, 1);

    // asynchronous reset mid-DATA, then a clean frame
    pushed[0] += 30;
    pulse(0);
    wait_state(0, 6, 400);
    repeat (3) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    cmp("async_rst_state", int'(st[0]), 0);
    cmp("async_rst_tx_en", int'(tx[0]), 0);
    cmp("async_rst_crc_en", int'(ce[0]), 0);
    cmp("async_rst_phase", int'(ph[0]), 0);
    cmp("async_rst_len", int'(plen[0]), 0);
    cmp("async_rst_others", int'({rd[0], ci[0], idx[0], pad[0], fcs[0],
                                  done[0], abrt[0], lerr[0]}), 0);
    pushed[0] = popped[0];
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    pushed[0] += 10;
    exp_q.push_back(exp_frame(0, 10, 1500));
    pulse(0);
    wait_obs(1, 1500);
    compare_next(o1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
